// File: rtl/ir_nec_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ir_nec_decoder
// Purpose  : NEC pulse-distance IR decoder with frame, repeat and error strobes.
//            Optional repeat-frame support is enabled by defining IR_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ir_nec_decoder #(
    parameter int TICK_CYCLES  = 500,
    parameter int NUM_BITS     = 32,
    parameter int STRICT_CHECK = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                irda,
    output logic [NUM_BITS-1:0] data,
    output logic                valid,
    output logic                rpt,
    output logic                err,
    output logic [1:0]          err_code,
    output logic                busy
);

    localparam int                 c_PRE_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX   = c_PRE_W'(TICK_CYCLES - 1);
    localparam int                 c_CNT_W     = $clog2(NUM_BITS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT  = c_CNT_W'(NUM_BITS - 1);

    localparam logic [10:0] c_LEAD_MARK_MIN  = 11'd800;
    localparam logic [10:0] c_LEAD_MARK_MAX  = 11'd1000;
    localparam logic [10:0] c_LEAD_SPACE_MIN = 11'd400;
    localparam logic [10:0] c_LEAD_SPACE_MAX = 11'd500;
`ifdef IR_REPEAT_EN
    localparam logic [10:0] c_RPT_SPACE_MIN  = 11'd180;
    localparam logic [10:0] c_RPT_SPACE_MAX  = 11'd270;
`endif
    localparam logic [10:0] c_BIT_MARK_MIN   = 11'd40;
    localparam logic [10:0] c_BIT_MARK_MAX   = 11'd80;
    localparam logic [10:0] c_ZERO_SPACE_MIN = 11'd40;
    localparam logic [10:0] c_ZERO_SPACE_MAX = 11'd80;
    localparam logic [10:0] c_ONE_SPACE_MIN  = 11'd140;
    localparam logic [10:0] c_ONE_SPACE_MAX  = 11'd200;
    localparam logic [10:0] c_RECOVER_IDLE   = 11'd1000;
    localparam logic [10:0] c_DUR_SAT        = 11'd2047;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LEAD_MARK  = 4'd1,
        S_LEAD_SPACE = 4'd2,
        S_BIT_MARK   = 4'd3,
        S_BIT_SPACE  = 4'd4,
        S_STOP_MARK  = 4'd5,
        S_RPT_MARK   = 4'd6,
        S_DONE       = 4'd7,
        S_RPT_DONE   = 4'd8,
        S_ERR        = 4'd9,
        S_RECOVER    = 4'd10
    } state_t;

    state_t                r_state;
    logic                  r_sync;
    logic                  r_s_ir;
    logic                  r_s_ir_d;
    logic [c_PRE_W-1:0]    r_pre;
    logic [10:0]           r_dur;
    logic [NUM_BITS-1:0]   r_shift;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [1:0]            r_pend_code;
    logic [NUM_BITS-1:0]   r_data;
    logic                  r_valid;
    logic                  r_rpt;
    logic                  r_err;
    logic [1:0]            r_err_code;
`ifdef IR_REPEAT_EN
    logic                  r_have_frame;
`endif
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_chk_ok;

    function automatic logic in_win(input logic [10:0] d, input logic [10:0] lo,
                                    input logic [10:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    // Line idles high, so the synchroniser resets to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= 1'b1;
            r_s_ir   <= 1'b1;
            r_s_ir_d <= 1'b1;
        end else begin
            r_sync   <= irda;
            r_s_ir   <= r_sync;
            r_s_ir_d <= r_s_ir;
        end
    end

    assign w_rise = r_s_ir & ~r_s_ir_d;
    assign w_fall = ~r_s_ir & r_s_ir_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_dur <= '0;
        end else if (w_rise || w_fall) begin
            r_pre <= '0;
            r_dur <= '0;
        end else if (r_pre == c_PRE_MAX) begin
            r_pre <= '0;
            if (r_dur != c_DUR_SAT)
                r_dur <= r_dur + 11'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    generate
        if (STRICT_CHECK != 0 && NUM_BITS == 32) begin : g_chk_strict
            assign w_chk_ok = (r_shift[31:24] == ~r_shift[23:16]);
        end else begin : g_chk_none
            assign w_chk_ok = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_pend_code  <= 2'b00;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_rpt        <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= 2'b00;
`ifdef IR_REPEAT_EN
            r_have_frame <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_rpt   <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: if (w_fall) r_state <= S_LEAD_MARK;
                S_LEAD_MARK: begin
                    if (w_rise) begin
                        if (in_win(r_dur, c_LEAD_MARK_MIN, c_LEAD_MARK_MAX)) r_state <= S_LEAD_SPACE;
                        else begin r_pend_code <= 2'b01; r_state <= S_ERR; end
                    end else if (r_dur > c_LEAD_MARK_MAX) begin
                        r_pend_code <= 2'b01; r_state <= S_ERR;
                    end
                end
                S_LEAD_SPACE: begin
                    if (w_fall) begin
                        if (in_win(r_dur, c_LEAD_SPACE_MIN, c_LEAD_SPACE_MAX)) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_BIT_MARK;
`ifdef IR_REPEAT_EN
                        end else if (in_win(r_dur, c_RPT_SPACE_MIN, c_RPT_SPACE_MAX)) begin
                            r_state <= S_RPT_MARK;
`endif
                        end else begin
                            r_pend_code <= 2'b01; r_state <= S_ERR;
                        end
                    end else if (r_dur > c_LEAD_SPACE_MAX) begin
                        r_pend_code <= 2'b01; r_state <= S_ERR;
                    end
                end
                S_BIT_MARK: begin
                    if (w_rise) begin
                        if (in_win(r_dur, c_BIT_MARK_MIN, c_BIT_MARK_MAX)) r_state <= S_BIT_SPACE;
                        else begin r_pend_code <= 2'b01; r_state <= S_ERR; end
                    end else if (r_dur > c_BIT_MARK_MAX) begin
                        r_pend_code <= 2'b01; r_state <= S_ERR;
                    end
                end
                S_BIT_SPACE: begin
                    if (w_fall) begin
                        if (in_win(r_dur, c_ZERO_SPACE_MIN, c_ZERO_SPACE_MAX) ||
                            in_win(r_dur, c_ONE_SPACE_MIN, c_ONE_SPACE_MAX)) begin
                            // Right shift into the MSB leaves the first bit at bit0.
                            r_shift   <= {in_win(r_dur, c_ONE_SPACE_MIN, c_ONE_SPACE_MAX),
                                          r_shift[NUM_BITS-1:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_state   <= (r_bit_cnt == c_LAST_BIT) ? S_STOP_MARK : S_BIT_MARK;
                        end else begin
                            r_pend_code <= 2'b01; r_state <= S_ERR;
                        end
                    end else if (r_dur > c_ONE_SPACE_MAX) begin
                        r_pend_code <= 2'b01; r_state <= S_ERR;
                    end
                end
                S_STOP_MARK, S_RPT_MARK: begin
                    if (w_rise) begin
                        if (in_win(r_dur, c_BIT_MARK_MIN, c_BIT_MARK_MAX))
                            r_state <= (r_state == S_STOP_MARK) ? S_DONE : S_RPT_DONE;
                        else begin r_pend_code <= 2'b01; r_state <= S_ERR; end
                    end else if (r_dur > c_BIT_MARK_MAX) begin
                        r_pend_code <= 2'b01; r_state <= S_ERR;
                    end
                end
                // End-of-frame errors strobe here directly so err keeps the same latency as valid.
                S_DONE: begin
                    if (!w_chk_ok) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'b10;
                        r_state    <= S_RECOVER;
                    end else begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
`ifdef IR_REPEAT_EN
                        r_have_frame <= 1'b1;
`endif
                        r_state <= S_IDLE;
                    end
                end
                S_RPT_DONE: begin
`ifdef IR_REPEAT_EN
                    if (r_have_frame) begin
                        r_rpt   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'b11;
                        r_state    <= S_RECOVER;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                S_ERR: begin
                    r_err      <= 1'b1;
                    r_err_code <= r_pend_code;
                    r_state    <= S_RECOVER;
                end
                S_RECOVER: if (r_s_ir && r_dur >= c_RECOVER_IDLE) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data     = r_data;
    assign valid    = r_valid;
    assign rpt      = r_rpt;
    assign err      = r_err;
    assign err_code = r_err_code;
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ir_nec_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_nec_decoder
// Purpose  : Directed self-checking bench for ir_nec_decoder (IR_REPEAT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ir_nec_decoder;

    localparam int TICK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        irda;
    logic [31:0] data;
    logic        valid;
    logic        rpt;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int n_rpt    = 0;
    int n_err    = 0;
    int v0, r0, e0, lat;
    logic [1:0] exp_rpt_code;

    ir_nec_decoder #(
        .TICK_CYCLES (TICK),
        .NUM_BITS    (32),
        .STRICT_CHECK(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .irda    (irda),
        .data    (data),
        .valid   (valid),
        .rpt     (rpt),
        .err     (err),
        .err_code(err_code),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (rpt)   n_rpt++;
        if (err)   n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int ticks);
        irda = lvl;
        repeat (ticks * TICK) @(negedge clk);
    endtask

    task automatic snap();
        v0 = n_valid;
        r0 = n_rpt;
        e0 = n_err;
    endtask

    task automatic send_bits(input logic [31:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, 56);
            hold(1'b1, f[i] ? 169 : 56);
        end
    endtask

    task automatic send_frame(input logic [31:0] f, output int latency);
        hold(1'b0, 900);
        hold(1'b1, 450);
        send_bits(f, 32);
        hold(1'b0, 56);
        irda    = 1'b1;
        latency = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (latency < 0 && (valid || rpt || err)) latency = i;
        end
    endtask

    task automatic send_repeat();
        hold(1'b0, 900);
        hold(1'b1, 225);
        hold(1'b0, 56);
        irda = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
`ifdef IR_REPEAT_EN
        exp_rpt_code = 2'b11;
`else
        exp_rpt_code = 2'b01;
`endif
        irda = 1'b1;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data",     data,            32'h0);
        check("reset_valid",    32'(valid),      32'h0);
        check("reset_rpt",      32'(rpt),        32'h0);
        check("reset_err",      32'(err),        32'h0);
        check("reset_err_code", 32'(err_code),   32'h0);
        check("reset_busy",     32'(busy),       32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Repeat frame with no prior good frame
        snap();
        send_repeat();
        check("rpt_nofr_err",  32'(n_err - e0), 32'd1);
        check("rpt_nofr_code", 32'(err_code),   32'(exp_rpt_code));
        check("rpt_nofr_rpt",  32'(n_rpt - r0), 32'd0);
        hold(1'b1, 1100);
        check("rpt_nofr_idle", 32'(busy),       32'h0);

        // Leader mark too short
        snap();
        hold(1'b0, 600);
        hold(1'b1, 1100);
        check("lead_short_err",   32'(n_err - e0),   32'd1);
        check("lead_short_code",  32'(err_code),     32'h1);
        check("lead_short_valid", 32'(n_valid - v0), 32'd0);
        check("lead_short_idle",  32'(busy),         32'h0);

        // Good frame after recovery
        snap();
        send_frame(32'hBA45FF00, lat);
        check("good_latency", 32'(lat),           32'd4);
        check("good_valid",   32'(n_valid - v0),  32'd1);
        check("good_data",    data,               32'hBA45FF00);
        check("good_err",     32'(n_err - e0),    32'd0);
        check("good_busy",    32'(busy),          32'h0);

        // Repeat after a good frame
        snap();
        send_repeat();
`ifdef IR_REPEAT_EN
        check("rpt_pulse",    32'(n_rpt - r0),    32'd1);
        check("rpt_err",      32'(n_err - e0),    32'd0);
`else
        check("rpt_dis_err",  32'(n_err - e0),    32'd1);
        check("rpt_dis_code", 32'(err_code),      32'h1);
        check("rpt_dis_rpt",  32'(n_rpt - r0),    32'd0);
        hold(1'b1, 1100);
`endif
        check("rpt_data",     data,               32'hBA45FF00);

        // Checksum failure
        snap();
        send_frame(32'hBB45FF00, lat);
        check("chk_err",   32'(n_err - e0),   32'd1);
        check("chk_code",  32'(err_code),     32'h2);
        check("chk_valid", 32'(n_valid - v0), 32'd0);
        check("chk_data",  data,              32'hBA45FF00);
        hold(1'b1, 1100);
        check("chk_idle",  32'(busy),         32'h0);

        // Leader mark timeout while the line is still low
        snap();
        hold(1'b0, 990);
        check("tmo_early_err",  32'(n_err - e0), 32'd0);
        check("tmo_early_busy", 32'(busy),       32'h1);
        hold(1'b0, 110);
        check("tmo_err",  32'(n_err - e0), 32'd1);
        check("tmo_code", 32'(err_code),   32'h1);
        hold(1'b1, 1100);
        check("tmo_idle", 32'(busy),       32'h0);

        // Reset in the middle of a frame
        snap();
        hold(1'b0, 900);
        hold(1'b1, 450);
        send_bits(32'hDD22EF10, 10);
        irda = 1'b0;
        repeat (20 * TICK) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_data",  data,             32'h0);
        check("mid_rst_busy",  32'(busy),        32'h0);
        check("mid_rst_code",  32'(err_code),    32'h0);
        check("mid_rst_valid", 32'(valid),       32'h0);
        irda = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 100);
        check("mid_rst_strobes", 32'(n_valid - v0 + n_err - e0 + n_rpt - r0), 32'd0);

        snap();
        send_frame(32'hDD22EF10, lat);
        check("post_rst_latency", 32'(lat),          32'd4);
        check("post_rst_valid",   32'(n_valid - v0), 32'd1);
        check("post_rst_data",    data,              32'hDD22EF10);
        check("post_rst_err",     32'(n_err - e0),   32'd0);
`ifdef IR_REPEAT_EN
        snap();
        send_repeat();
        check("post_rst_rpt",      32'(n_rpt - r0), 32'd1);
        check("post_rst_rpt_data", data,            32'hDD22EF10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
